count_enable_seq: RTL and testbench
===================================

// Module: count_enable_seq
// PURPOSE
//  Upstream stage of first_counter: drives its enable input.
//  Turns a start/stop request into a paced train of 1-cycle enable pulses:
//  one pulse every PRESCALE+1 clocks, for a burst of BURST_LEN pulses or continuously.
//  Reports busy/done so the controller knows when the counter has advanced the requested amount.
// PARAMETERS
//  PRE_W  8  width of prescale input and internal prescaler counter
//  LEN_W  8  width of burst_len input, pulse counter and pulse_count output
// PORTS
//  clock        in   1      single system clock, all logic on rising edge
//  reset        in   1      synchronous, active-high; clears all state
//  start        in   1      begin a sequence; sampled only in IDLE
//  stop         in   1      abort the sequence; acts in RUN (and IDLE, see below)
//  prescale     in   PRE_W  clocks between pulses minus 1; latched at start
//  burst_len    in   LEN_W  pulses per burst; 0 = continuous; latched at start
//  enable       out  1      registered 1-cycle pulse to first_counter.enable
//  busy         out  1      high while state != IDLE
//  done         out  1      registered 1-cycle pulse: burst completed
//  pulse_count  out  LEN_W  enables issued in the current or most recent sequence
// BEHAVIOUR
//  Reset: state=IDLE, enable=0, done=0, busy=0, pulse_count=0, pre_cnt=0.
//   Reset at any point, including mid-burst, returns to reset values at that edge. No done pulse.
//  Outputs enable and done are flops; busy decodes state; pulse_count is the pulse counter flop.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//   stop=1 -> stay IDLE (stop beats simultaneous start).
//   start=1 -> latch pre_reg<=prescale and len_reg<=burst_len; pre_cnt<=0; pulse_count<=0; go RUN.
//   done<=0 and enable<=0, except on the DONE->IDLE edge.
//  RUN, evaluated each edge in priority order:
//   1. stop=1 -> IDLE, enable<=0, done stays 0, pulse_count holds.
//   2. pre_cnt!=pre_reg -> pre_cnt<=pre_cnt+1, enable<=0.
//   3. pre_cnt==pre_reg -> pre_cnt<=0, enable<=1, pulse_count<=pulse_count+1.
//      If additionally len_reg!=0 and pulse_count+1==len_reg -> go DONE.
//   start is ignored in RUN.
//  DONE (one cycle): enable<=0, done<=1, go IDLE. stop is ignored here.
//   So done is high in the first IDLE cycle after the last enable.
//  Latency: the first enable is high PRE+1 edges after the start-sampling edge.
//   Edge 0 samples start, with PRE = the latched prescale.
//   The nth enable is high after edge n*(PRE+1).
//  prescale=0 gives back-to-back enables every cycle.
//  Continuous mode (len_reg=0): pulse_count wraps 2^LEN_W-1 -> 0 silently; never reaches DONE.
//  burst_len = 2^LEN_W-1 is a legal maximum burst.
//  All arithmetic is unsigned and modulo its register width.
// CONFIGURATION
//  COUNT_SEQ_PAUSE_EN defined:
//   Adds input port pause (1 bit), placed after stop.
//   In RUN with stop=0 and pause=1: pre_cnt and pulse_count hold, enable<=0, state stays RUN.
//   stop beats pause. pause has no effect in IDLE or DONE.
//   The pulse schedule resumes exactly where it froze.
//  COUNT_SEQ_PAUSE_EN undefined:
//   No pause port. Behaviour is identical to the defined build with pause tied to 0.
// TESTING
//  1 Hold reset 2 cycles, start=1 during reset
//    -> enable=0, done=0, busy=0, pulse_count=0 throughout; still IDLE after release.
//  2 prescale=0, burst_len=3, start at edge 0
//    -> enable high after edges 1,2,3; done high only after edge 4; busy high after edges 0..3.
//    -> first_counter advances by exactly 3.
//  3 prescale=2, burst_len=2
//    -> enable after edges 3 and 6 only; done after edge 7; pulse_count=2.
//  4 prescale=1, burst_len=10, stop=1 at edge 5
//    -> enables after edges 2 and 4; IDLE after edge 5; no done; pulse_count=2.
//  5 start=1 and stop=1 together in IDLE -> stays IDLE.
//    Then prescale=0, burst_len=0 -> continuous enable; pulse_count wraps 255->0 after 256 pulses.
//  6 With COUNT_SEQ_PAUSE_EN: prescale=0, burst_len=4, pause=1 for 3 cycles after pulse 2
//    -> enable low for those 3 cycles, pulse_count holds at 2.
//    -> then pulses 3 and 4 follow; done one cycle later.
//    -> Also reset asserted mid-pause -> reset values.

Source files
------------

// File: rtl/count_enable_seq.sv
// Paced enable generator for first_counter: start/stop requests become a train of 1-cycle
// enable pulses every PRESCALE+1 clocks, burst or continuous. Optional pause port: COUNT_SEQ_PAUSE_EN.
module count_enable_seq #(
    parameter int PRE_W = 8,
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
`ifdef COUNT_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [PRE_W-1:0] prescale,
    input  logic [LEN_W-1:0] burst_len,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] pulse_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [PRE_W-1:0]   pre_reg, pre_next;
    logic [LEN_W-1:0]   len_reg, len_next;
    logic [PRE_W-1:0]   pre_cnt_reg, pre_cnt_next;
    logic [LEN_W-1:0]   count_reg, count_next;
    logic               enable_reg, enable_next;
    logic               done_reg, done_next;
    logic               pause_int;
    logic [LEN_W-1:0]   count_inc;

`ifdef COUNT_SEQ_PAUSE_EN
    assign pause_int = pause;
`else
    assign pause_int = 1'b0;
`endif

    assign count_inc = count_reg + LEN_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pre_reg     <= '0;
            len_reg     <= '0;
            pre_cnt_reg <= '0;
            count_reg   <= '0;
            enable_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pre_reg     <= pre_next;
            len_reg     <= len_next;
            pre_cnt_reg <= pre_cnt_next;
            count_reg   <= count_next;
            enable_reg  <= enable_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pre_next     = pre_reg;
        len_next     = len_reg;
        pre_cnt_next = pre_cnt_reg;
        count_next   = count_reg;
        enable_next  = 1'b0;
        done_next    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // stop wins over a simultaneous start
                if (!stop && start) begin
                    pre_next     = prescale;
                    len_next     = burst_len;
                    pre_cnt_next = '0;
                    count_next   = '0;
                    state_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (pause_int) begin
                    state_next = ST_RUN;
                end else if (pre_cnt_reg != pre_reg) begin
                    pre_cnt_next = pre_cnt_reg + PRE_W'(1);
                end else begin
                    pre_cnt_next = '0;
                    enable_next  = 1'b1;
                    count_next   = count_inc;
                    // a zero length means run until stopped; the count just wraps
                    if (len_reg != '0 && count_inc == len_reg) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign enable      = enable_reg;
    assign done        = done_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign pulse_count = count_reg;

endmodule

// File: tb/tb_count_enable_seq.sv
// Self-checking bench for count_enable_seq: directed scenarios plus random traffic checked
// against a pulse-schedule model (pulse n lands after n*(PRE+1) un-paused run cycles).
module tb_count_enable_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] prescale  = 8'd0;
    logic [7:0] burst_len = 8'd0;
    logic       enable, busy, done;
    logic [7:0] pulse_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_active, m_done_pending, m_enable, m_done, m_busy;
    int         m_pre, m_len, m_ticks, m_pulses, n_txn;
    logic [7:0] m_count;

    count_enable_seq #(.PRE_W(8), .LEN_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
`ifdef COUNT_SEQ_PAUSE_EN
        .pause       (pause),
`endif
        .prescale    (prescale),
        .burst_len   (burst_len),
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    always #5 clock = ~clock;

    task automatic model_update();
        if (reset) begin
            m_active = 0; m_done_pending = 0; m_enable = 0; m_done = 0;
            m_ticks = 0; m_pulses = 0; m_count = 8'd0;
        end else if (m_done_pending) begin
            m_done_pending = 0; m_enable = 0; m_done = 1;
        end else if (!m_active) begin
            m_enable = 0; m_done = 0;
            if (start && !stop) begin
                m_active = 1; m_pre = int'(prescale); m_len = int'(burst_len);
                m_ticks = 0; m_pulses = 0; m_count = 8'd0;
                n_txn++;
            end
        end else begin
            m_enable = 0; m_done = 0;
            if (stop) begin
                m_active = 0;
            end else if (!pause) begin
                m_ticks++;
                if (m_ticks % (m_pre + 1) == 0) begin
                    m_enable = 1;
                    m_pulses++;
                    m_count = 8'(m_pulses % 256);
                    if (m_len != 0 && m_pulses == m_len) begin
                        m_active = 0;
                        m_done_pending = 1;
                    end
                end
            end
        end
        m_busy = m_active || m_done_pending;
    endtask

    // one clock edge: model follows the inputs seen at the edge; outputs sampled 1ns later
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1; start = 1; prescale = 8'd3; burst_len = 8'd5;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({enable, done, busy, pulse_count} !== 11'd0) begin
                errors++;
                $display("FAIL reset_hold edge=%0d: got en=%b done=%b busy=%b cnt=%0d, want all 0",
                         k, enable, done, busy, pulse_count);
            end
        end
        reset = 0; start = 0;
        step();
        checks++;
        if (busy !== 1'b0 || enable !== 1'b0 || pulse_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b en=%b cnt=%0d, want 0 0 0", busy, enable, pulse_count);
        end
    endtask

    task automatic test_short_burst();
        int en_cnt = 0;
        prescale = 8'd0; burst_len = 8'd3; start = 1;
        step();
        start = 0;
        checks++;
        if (busy !== 1'b1 || enable !== 1'b0) begin
            errors++;
            $display("FAIL short_start: got busy=%b en=%b, want busy=1 en=0", busy, enable);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            en_cnt += int'(enable);
            checks++;
            if (enable !== (k >= 1 && k <= 3) || done !== (k == 4) || busy !== (k <= 3)) begin
                errors++;
                $display("FAIL short_burst edge=%0d: got en=%b done=%b busy=%b, want en=%b done=%b busy=%b",
                         k, enable, done, busy, (k >= 1 && k <= 3), (k == 4), (k <= 3));
            end
        end
        checks++;
        if (en_cnt != 3 || pulse_count !== 8'd3) begin
            errors++;
            $display("FAIL short_total: got enables=%0d cnt=%0d, want 3 3", en_cnt, pulse_count);
        end
    endtask

    task automatic test_prescale();
        prescale = 8'd2; burst_len = 8'd2; start = 1;
        step();
        start = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            checks++;
            if (enable !== (k == 3 || k == 6) || done !== (k == 7) || busy !== (k <= 6)) begin
                errors++;
                $display("FAIL prescale edge=%0d: got en=%b done=%b busy=%b, want en=%b done=%b busy=%b",
                         k, enable, done, busy, (k == 3 || k == 6), (k == 7), (k <= 6));
            end
        end
        checks++;
        if (pulse_count !== 8'd2) begin
            errors++;
            $display("FAIL prescale_count: got %0d, want 2", pulse_count);
        end
    endtask

    task automatic test_stop();
        prescale = 8'd1; burst_len = 8'd10; start = 1;
        step();
        start = 0;
        for (int k = 1; k <= 8; k++) begin
            stop = (k == 5);
            step();
            checks++;
            if (enable !== (k == 2 || k == 4) || done !== 1'b0 || busy !== (k <= 4)) begin
                errors++;
                $display("FAIL stop edge=%0d: got en=%b done=%b busy=%b, want en=%b done=0 busy=%b",
                         k, enable, done, busy, (k == 2 || k == 4), (k <= 4));
            end
        end
        stop = 0;
        checks++;
        if (pulse_count !== 8'd2) begin
            errors++;
            $display("FAIL stop_count: got %0d, want 2", pulse_count);
        end
    endtask

    task automatic test_continuous();
        prescale = 8'd0; burst_len = 8'd0; start = 1; stop = 1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_beats_start: got busy=%b, want 0", busy);
        end
        stop = 0;
        step();
        start = 0;
        for (int k = 1; k <= 260; k++) begin
            step();
            checks++;
            if ({enable, done, busy, pulse_count} !== {m_enable, m_done, m_busy, m_count}) begin
                errors++;
                $display("FAIL continuous edge=%0d: got en=%b done=%b busy=%b cnt=%0d, want %b %b %b %0d",
                         k, enable, done, busy, pulse_count, m_enable, m_done, m_busy, m_count);
            end
            if (k == 255 || k == 256) begin
                checks++;
                if (pulse_count !== ((k == 255) ? 8'd255 : 8'd0) || enable !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap edge=%0d: got cnt=%0d en=%b, want cnt=%0d en=1",
                             k, pulse_count, enable, (k == 255) ? 255 : 0);
                end
            end
        end
        stop = 1;
        step();
        stop = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL continuous_stop: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_max_burst();
        int done_edge = -1;
        prescale = 8'd0; burst_len = 8'd255; start = 1;
        step();
        start = 0;
        for (int k = 1; k <= 300 && done_edge < 0; k++) begin
            step();
            checks++;
            if ({enable, done, busy, pulse_count} !== {m_enable, m_done, m_busy, m_count}) begin
                errors++;
                $display("FAIL max_burst edge=%0d: got en=%b done=%b busy=%b cnt=%0d, want %b %b %b %0d",
                         k, enable, done, busy, pulse_count, m_enable, m_done, m_busy, m_count);
            end
            if (done === 1'b1) done_edge = k;
        end
        checks++;
        if (done_edge != 256 || pulse_count !== 8'd255) begin
            errors++;
            $display("FAIL max_burst_done: got done_edge=%0d cnt=%0d, want 256 255", done_edge, pulse_count);
        end
    endtask

`ifdef COUNT_SEQ_PAUSE_EN
    task automatic test_pause();
        prescale = 8'd0; burst_len = 8'd4; start = 1;
        step();
        start = 0;
        for (int k = 1; k <= 10; k++) begin
            pause = (k >= 3 && k <= 5);
            step();
            checks++;
            if (enable !== (k == 1 || k == 2 || k == 6 || k == 7) || done !== (k == 8)
                || ((k >= 2 && k <= 5) && pulse_count !== 8'd2)) begin
                errors++;
                $display("FAIL pause edge=%0d: got en=%b done=%b cnt=%0d", k, enable, done, pulse_count);
            end
        end
        pause = 0;
        start = 1;
        step();
        start = 0;
        step(); step();
        pause = 1;
        step();
        reset = 1;
        step();
        reset = 0; pause = 0;
        checks++;
        if ({enable, done, busy, pulse_count} !== 11'd0) begin
            errors++;
            $display("FAIL pause_reset: got en=%b done=%b busy=%b cnt=%0d, want all 0",
                     enable, done, busy, pulse_count);
        end
    endtask
`endif

    task automatic test_random();
        int last_txn;
        for (int k = 0; k < 1500; k++) begin
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            prescale  = 8'($urandom_range(0, 3));
            burst_len = 8'($urandom_range(0, 8));
`ifdef COUNT_SEQ_PAUSE_EN
            pause     = ($urandom_range(0, 5) == 0);
`endif
            last_txn = n_txn;
            step();
            if (n_txn != last_txn)
                $display("txn %0d: cycle=%0d prescale=%0d burst_len=%0d", n_txn, k, m_pre, m_len);
            checks++;
            if ({enable, done, busy, pulse_count} !== {m_enable, m_done, m_busy, m_count}) begin
                errors++;
                $display("FAIL random cycle=%0d: got en=%b done=%b busy=%b cnt=%0d, want %b %b %b %0d",
                         k, enable, done, busy, pulse_count, m_enable, m_done, m_busy, m_count);
            end
        end
        start = 0; stop = 0; reset = 0; pause = 0;
    endtask

    initial begin
        test_reset();
        test_short_burst();
        test_prescale();
        test_stop();
        test_continuous();
        test_max_burst();
`ifdef COUNT_SEQ_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
